regfile_wr_arbiter: RTL and testbench
=====================================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter AGE_MAX, default 4: number of consecutive cycles requester B may be stalled before it is force-granted.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port a_valid  input  1  pipeline write-back request.
REQ-005 SHALL have port a_reg  input  5  destination register of A.
REQ-006 SHALL have port a_data  input  32  write data of A.
REQ-007 SHALL have port a_ready  output  1  A accepted this cycle.
REQ-008 SHALL have ports b_valid, b_reg, b_data, b_ready: same widths and meaning for the multi-cycle unit B.
REQ-009 SHALL have port rsv_valid  input  1  B issues an operation that will later write rsv_reg.
REQ-010 SHALL have port rsv_reg  input  5  register reserved by B.
REQ-011 SHALL have port busy  output  32  bit i set = write to register i from B still pending.
REQ-012 SHALL have port _regWrite  output  1  register-file write enable.
REQ-013 SHALL have port writeReg  output  5  register-file write address.
REQ-014 SHALL have port writeData  output  32  register-file write data.

Function
REQ-015 SHALL grant at most one requester per cycle; a transfer occurs when valid and ready are both high at posedge.
REQ-016 SHALL use fixed priority A over B unless the age counter equals AGE_MAX, in which case B is granted and a_ready is 0.
REQ-017 SHALL drive a_ready and b_ready combinationally from valids and age counter; ready SHALL never be asserted without the matching valid.
REQ-018 SHALL maintain a saturating age counter: increment while b_valid high and B not granted; clear on B grant or b_valid low.
REQ-019 SHALL register the granted request so _regWrite, writeReg, writeData are valid one cycle after acceptance and held stable the whole cycle (the register file samples on negedge).
REQ-020 SHALL drive _regWrite 0 in any cycle following no transfer; writeReg and writeData hold their previous values.
REQ-021 SHALL accept requests to register 0 (ready asserted) but SHALL NOT assert _regWrite for them.
REQ-022 SHALL set busy[rsv_reg] on posedge when rsv_valid high and rsv_reg != 0; reservations to register 0 are ignored.
REQ-023 SHALL clear busy[b_reg] on the posedge a B transfer is accepted.
REQ-024 SHALL, when reservation and B clear hit the same register in one cycle, leave the bit set (new reservation wins).
REQ-025 SHALL NOT modify busy on A transfers.
REQ-026 SHALL keep busy[0] permanently 0.

Reset
REQ-027 SHALL on rst_n low, immediately and independent of clk: _regWrite=0, writeReg=0, writeData=0, busy=0, age counter=0.
REQ-028 SHALL drive a_ready=0 and b_ready=0 while rst_n is low.
REQ-029 SHALL discard any request accepted in the cycle reset asserts; no register-file write follows reset release.
REQ-030 SHALL resume arbitration on the first posedge after rst_n deasserts.

Structure
REQ-031 SHALL place register-count (32), address width (5), data width (32) and default AGE_MAX in a shared package used by this block and the register file.
REQ-032 SHALL implement the busy vector as one sub-module, regfile_scoreboard (set/clear ports, busy output).
REQ-033 SHALL keep arbitration and output register in the top module; no other sub-modules.

Verification
REQ-034 SHALL cover: a_valid=1 a_reg=5 a_data=0x1234 with b idle -> a_ready=1; next cycle _regWrite=1 writeReg=5 writeData=0x1234.
REQ-035 SHALL cover: a_valid and b_valid held high continuously, AGE_MAX=4 -> A granted 4 cycles, 5th cycle b_ready=1 a_ready=0, counter then 0.
REQ-036 SHALL cover: a_valid=1 a_reg=0 a_data=0xFFFF -> a_ready=1; next cycle _regWrite=0.
REQ-037 SHALL cover: rsv_valid rsv_reg=7 -> busy=0x80; later B write to 7 with simultaneous rsv_reg=7 -> busy stays 0x80; next B write to 7 alone -> busy=0.
REQ-038 SHALL cover: rst_n low mid-cycle after an accepted write -> outputs and busy 0 immediately; no _regWrite after release until a new transfer.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared register-file geometry and the write-port types that the write arbiter
// and the register file both depend on.
package regfile_wr_arbiter_pkg;

    localparam int NUM_REGS        = 32;
    localparam int ADDR_W          = 5;
    localparam int DATA_W          = 32;
    localparam int AGE_MAX_DEFAULT = 4;

    typedef logic [ADDR_W-1:0]   reg_addr_t;
    typedef logic [DATA_W-1:0]   reg_data_t;
    typedef logic [NUM_REGS-1:0] reg_mask_t;

    // One registered register-file write, as presented to the register file.
    typedef struct packed {
        logic      en;
        reg_addr_t addr;
        reg_data_t data;
    } wr_port_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_A    = 2'd1,
        GRANT_B    = 2'd2
    } grant_t;

    // Register 0 is hard-wired, so it never maps onto a mask bit.
    function automatic reg_mask_t reg_onehot(input reg_addr_t addr);
        reg_mask_t mask;
        mask    = '0;
        mask[addr] = 1'b1;
        mask[0] = 1'b0;
        return mask;
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, set when
// unit B reserves a destination and cleared when B finally writes it back.
module regfile_scoreboard
    import regfile_wr_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_en,
    input  reg_addr_t  set_reg,
    input  logic       clr_en,
    input  reg_addr_t  clr_reg,
    output reg_mask_t  busy
);

    reg_mask_t busy_reg;
    reg_mask_t busy_next;
    reg_mask_t set_mask;
    reg_mask_t clr_mask;

    always_comb begin
        set_mask = set_en ? reg_onehot(set_reg) : '0;
        clr_mask = clr_en ? reg_onehot(clr_reg) : '0;
    end

    // Set is applied after clear so a fresh reservation survives a same-cycle
    // write-back to the same register.
    always_comb begin
        busy_next    = (busy_reg & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy = busy_reg;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Two-requester write-back arbiter for the register file: pipeline A has
// priority, multi-cycle unit B is force-granted once it has waited AGE_MAX cycles.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int AGE_MAX = AGE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,

    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,

    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_reg,
    output logic [NUM_REGS-1:0] busy,

    output logic              _regWrite,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData
);

    localparam int AGE_W = (AGE_MAX < 1) ? 1 : $clog2(AGE_MAX + 1);
    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(AGE_MAX);

    grant_t          grant;
    logic            force_b;
    logic [AGE_W-1:0] age_reg;
    logic [AGE_W-1:0] age_next;
    wr_port_t        wr_reg;
    wr_port_t        wr_next;

    assign force_b = b_valid && (age_reg == AGE_LIMIT);

    // Readies are gated by rst_n so nothing is handshaken while reset is held.
    always_comb begin
        grant = GRANT_NONE;
        if (rst_n) begin
            if (force_b) begin
                grant = GRANT_B;
            end else if (a_valid) begin
                grant = GRANT_A;
            end else if (b_valid) begin
                grant = GRANT_B;
            end
        end
    end

    assign a_ready = (grant == GRANT_A);
    assign b_ready = (grant == GRANT_B);

    // Age counts consecutive cycles in which B waited; any B grant or a gap
    // in b_valid starts the count over.
    always_comb begin
        age_next = age_reg;
        if (!b_valid || (grant == GRANT_B)) begin
            age_next = '0;
        end else if (age_reg != AGE_LIMIT) begin
            age_next = age_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_reg <= '0;
        end else begin
            age_reg <= age_next;
        end
    end

    // Address and data of the winner are captured even for register 0; only
    // the enable is suppressed, and idle cycles keep the last address/data.
    always_comb begin
        wr_next    = wr_reg;
        wr_next.en = 1'b0;
        unique case (grant)
            GRANT_A: begin
                wr_next.en   = (a_reg != '0);
                wr_next.addr = a_reg;
                wr_next.data = a_data;
            end
            GRANT_B: begin
                wr_next.en   = (b_reg != '0);
                wr_next.addr = b_reg;
                wr_next.data = b_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_reg <= '0;
        end else begin
            wr_reg <= wr_next;
        end
    end

    assign _regWrite = wr_reg.en;
    assign writeReg  = wr_reg.addr;
    assign writeData = wr_reg.data;

    regfile_scoreboard u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (rsv_valid),
        .set_reg (rsv_reg),
        .clr_en  (b_ready),
        .clr_reg (b_reg),
        .busy    (busy)
    );

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: write-back latency, priority and aging,
// register-0 writes, scoreboard reservations and asynchronous reset.
module tb_regfile_wr_arbiter;
    import regfile_wr_arbiter_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              a_valid, b_valid, rsv_valid;
    logic [ADDR_W-1:0] a_reg, b_reg, rsv_reg;
    logic [DATA_W-1:0] a_data, b_data;
    logic              a_ready, b_ready;
    logic [NUM_REGS-1:0] busy;
    logic              _regWrite;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.AGE_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_reg     (a_reg),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_reg     (b_reg),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .rsv_valid (rsv_valid),
        .rsv_reg   (rsv_reg),
        .busy      (busy),
        ._regWrite (_regWrite),
        .writeReg  (writeReg),
        .writeData (writeData)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Returns 1 ns after the active edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_valid = 1'b0; a_reg = '0; a_data = '0;
        b_valid = 1'b0; b_reg = '0; b_data = '0;
        rsv_valid = 1'b0; rsv_reg = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        // Requests present during reset must not be acknowledged.
        a_valid = 1'b1; b_valid = 1'b1; a_reg = 5'd3; b_reg = 5'd4;
        #12;
        check_eq("rst_a_ready",   a_ready,   0);
        check_eq("rst_b_ready",   b_ready,   0);
        check_eq("rst_regWrite",  _regWrite, 0);
        check_eq("rst_writeReg",  writeReg,  0);
        check_eq("rst_writeData", writeData, 0);
        check_eq("rst_busy",      busy,      0);
        clear_inputs();
        #5 rst_n = 1'b1;
        tick();

        // Single A write.
        a_valid = 1'b1; a_reg = 5'd5; a_data = 32'h1234;
        #1;
        check_eq("a5_a_ready", a_ready, 1);
        check_eq("a5_b_ready", b_ready, 0);
        tick();
        a_valid = 1'b0;
        check_eq("a5_regWrite",  _regWrite, 1);
        check_eq("a5_writeReg",  writeReg,  5);
        check_eq("a5_writeData", writeData, 32'h1234);
        tick();
        check_eq("idle_regWrite",  _regWrite, 0);
        check_eq("idle_writeReg",  writeReg,  5);
        check_eq("idle_writeData", writeData, 32'h1234);

        // Write to register 0 is accepted but never reaches the file.
        a_valid = 1'b1; a_reg = 5'd0; a_data = 32'hFFFF;
        #1;
        check_eq("r0_a_ready", a_ready, 1);
        tick();
        a_valid = 1'b0;
        check_eq("r0_regWrite", _regWrite, 0);

        // B alone is granted immediately.
        b_valid = 1'b1; b_reg = 5'd6; b_data = 32'hB6;
        #1;
        check_eq("b6_b_ready", b_ready, 1);
        check_eq("b6_a_ready", a_ready, 0);
        tick();
        b_valid = 1'b0;
        check_eq("b6_writeReg",  writeReg,  6);
        check_eq("b6_writeData", writeData, 32'hB6);

        // Contention: A wins 4 cycles, B forced on the 5th, A wins again.
        // Second pass follows a one-cycle b_valid gap, which must restart aging.
        a_valid = 1'b1; a_reg = 5'd1;
        b_reg = 5'd2; b_data = 32'hB0B0;
        for (int pass = 0; pass < 2; pass++) begin
            b_valid = 1'b1;
            for (int k = 0; k < 6; k++) begin
                a_data = 32'h100 + 32'(k);
                #1;
                check_eq($sformatf("age%0d_k%0d_a_ready", pass, k), a_ready, (k != 4) ? 1 : 0);
                check_eq($sformatf("age%0d_k%0d_b_ready", pass, k), b_ready, (k == 4) ? 1 : 0);
                tick();
                check_eq($sformatf("age%0d_k%0d_writeReg", pass, k), writeReg, (k != 4) ? 1 : 2);
                check_eq($sformatf("age%0d_k%0d_writeData", pass, k), writeData,
                         (k != 4) ? 32'h100 + 32'(k) : 32'hB0B0);
            end
            b_valid = 1'b0;
            tick();
        end
        clear_inputs();
        tick();

        // Scoreboard: reserve 7, ignore a reservation of register 0.
        rsv_valid = 1'b1; rsv_reg = 5'd7;
        tick();
        check_eq("rsv7_busy", busy, 32'h80);
        rsv_reg = 5'd0;
        tick();
        check_eq("rsv0_busy", busy, 32'h80);
        // B write to 7 with a simultaneous re-reservation of 7.
        rsv_reg = 5'd7;
        b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h77;
        #1;
        check_eq("b7rsv_b_ready", b_ready, 1);
        tick();
        check_eq("b7rsv_busy",     busy,      32'h80);
        check_eq("b7rsv_regWrite", _regWrite, 1);
        check_eq("b7rsv_writeReg", writeReg,  7);
        rsv_valid = 1'b0;
        tick();
        check_eq("b7_busy", busy, 32'h0);
        b_valid = 1'b0;
        // A write does not clear a reservation.
        rsv_valid = 1'b1; rsv_reg = 5'd3;
        tick();
        rsv_valid = 1'b0;
        a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h33;
        tick();
        a_valid = 1'b0;
        check_eq("a3_busy",     busy,      32'h8);
        check_eq("a3_writeReg", writeReg,  3);

        // Reset asserted mid-cycle after an accepted write.
        a_valid = 1'b1; a_reg = 5'd9; a_data = 32'hABCD;
        tick();
        check_eq("pre_rst_regWrite", _regWrite, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_regWrite",  _regWrite, 0);
        check_eq("mid_rst_writeReg",  writeReg,  0);
        check_eq("mid_rst_writeData", writeData, 0);
        check_eq("mid_rst_busy",      busy,      0);
        check_eq("mid_rst_a_ready",   a_ready,   0);
        clear_inputs();
        tick();
        #3 rst_n = 1'b1;
        tick();
        check_eq("post_rst1_regWrite", _regWrite, 0);
        tick();
        check_eq("post_rst2_regWrite", _regWrite, 0);
        a_valid = 1'b1; a_reg = 5'd10; a_data = 32'hA10;
        tick();
        a_valid = 1'b0;
        check_eq("post_rst_new_regWrite",  _regWrite, 1);
        check_eq("post_rst_new_writeData", writeData, 32'hA10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
